// File: rtl/jt12_pkg.sv
// jt12_pkg: shared constants for the JT12 accumulator scheduler and operator pipeline.
//   OP_*         operator encoding in frame order (S1, S3, S2, S4)
//   FRAME_SLOTS  slots per frame for the default channel count
//   CARRIER_MASK per-algorithm carrier bits, bit index = operator code
package jt12_pkg;
    localparam logic [1:0] OP_S1 = 2'd0;
    localparam logic [1:0] OP_S3 = 2'd1;
    localparam logic [1:0] OP_S2 = 2'd2;
    localparam logic [1:0] OP_S4 = 2'd3;
    localparam int NCH_DEF = 6;
    localparam int FRAME_SLOTS = 4 * NCH_DEF;
    // alg 7 -> all, 5..6 -> S3/S2/S4, 4 -> S2/S4, 0..3 -> S4 only
    localparam logic [7:0][3:0] CARRIER_MASK = {
        4'hF, 4'hE, 4'hE, 4'hC, 4'h8, 4'h8, 4'h8, 4'h8
    };
endpackage

// File: rtl/jt12_carrier_dec.sv
// jt12_carrier_dec: flags whether an operator is a carrier under a given algorithm.
//   alg     algorithm 0..7
//   op      operator code (0=S1, 1=S3, 2=S2, 3=S4)
//   carrier high when this operator feeds the output
import jt12_pkg::*;

module jt12_carrier_dec (
    input  logic [2:0] alg,
    input  logic [1:0] op,
    output logic       carrier
);
    assign carrier = CARRIER_MASK[alg][op];
endmodule

// File: rtl/jt12_acc_sched.sv
// jt12_acc_sched: 24-slot frame scheduler driving the L/R output accumulators.
//   clk, rst                 clock, asynchronous active-high reset
//   clk_en                   slot advance
//   cfg_we/ch/alg/pan        shadowed per-channel configuration write
//   dac_en                   replace last channel with the DAC, taken at frame start
//   slot, ch, op             current slot and its channel/operator split
//   sum_en_l, sum_en_r       accumulator sum enables
//   zero                     frame start strobe
//   dac_sel                  current slot carries the DAC sample
import jt12_pkg::*;

module jt12_acc_sched #(
    parameter int NCH = NCH_DEF,
    parameter int SW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_ch,
    input  logic [2:0]    cfg_alg,
    input  logic [1:0]    cfg_pan,
    input  logic          dac_en,
    output logic [SW-1:0] slot,
    output logic [2:0]    ch,
    output logic [1:0]    op,
    output logic          sum_en_l,
    output logic          sum_en_r,
    output logic          zero,
    output logic          dac_sel
);
    localparam logic [SW-1:0] LAST_SLOT = SW'(4 * NCH - 1);
    localparam logic [2:0]    LAST_CH   = 3'(NCH - 1);

    logic [2:0]    alg_s [NCH];
    logic [2:0]    alg_a [NCH];
    logic [2:0]    alg_nx [NCH];
    logic [1:0]    pan_s [NCH];
    logic [1:0]    pan_a [NCH];
    logic [1:0]    pan_nx [NCH];
    logic          dac_act, dac_nx, wrap, carrier, dac_mute, sel_n;
    logic [SW-1:0] slot_n;
    logic [2:0]    ch_n;
    logic [1:0]    op_n;

    // Outputs are decoded from the next slot and next active configuration,
    // so the registered outputs line up with the registered slot.
    always_comb begin
        wrap   = clk_en && slot == LAST_SLOT;
        slot_n = slot == LAST_SLOT ? '0 : slot + 1'b1;
        ch_n   = ch == LAST_CH ? 3'd0 : ch + 3'd1;
        op_n   = ch == LAST_CH ? op + 2'd1 : op;
        for (int i = 0; i < NCH; i++) begin
            // a write landing on the boundary edge bypasses staging
            alg_nx[i] = wrap ? (cfg_we && cfg_ch == 3'(i) ? cfg_alg : alg_s[i]) : alg_a[i];
            pan_nx[i] = wrap ? (cfg_we && cfg_ch == 3'(i) ? cfg_pan : pan_s[i]) : pan_a[i];
        end
        dac_nx   = wrap ? dac_en : dac_act;
        dac_mute = dac_nx && ch_n == LAST_CH;
        sel_n    = dac_nx && slot_n == LAST_SLOT;
    end

    jt12_carrier_dec u_dec (
        .alg     (alg_nx[ch_n]),
        .op      (op_n),
        .carrier (carrier)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alg_s <= '{default: 3'd0};
            pan_s <= '{default: 2'b11};
        end else if (cfg_we && cfg_ch <= LAST_CH) begin
            alg_s[cfg_ch] <= cfg_alg;
            pan_s[cfg_ch] <= cfg_pan;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot     <= LAST_SLOT;
            ch       <= LAST_CH;
            op       <= OP_S4;
            alg_a    <= '{default: 3'd0};
            pan_a    <= '{default: 2'b11};
            dac_act  <= 1'b0;
            zero     <= 1'b0;
            dac_sel  <= 1'b0;
            sum_en_l <= 1'b0;
            sum_en_r <= 1'b0;
        end else if (clk_en) begin
            slot     <= slot_n;
            ch       <= ch_n;
            op       <= op_n;
            alg_a    <= alg_nx;
            pan_a    <= pan_nx;
            dac_act  <= dac_nx;
            zero     <= slot_n == '0;
            dac_sel  <= sel_n;
            // the DAC slot is summed on pan alone
            sum_en_l <= sel_n ? pan_nx[ch_n][1] : carrier & pan_nx[ch_n][1] & ~dac_mute;
            sum_en_r <= sel_n ? pan_nx[ch_n][0] : carrier & pan_nx[ch_n][0] & ~dac_mute;
        end
    end
endmodule

// File: doc/jt12_acc_sched.md
# jt12_acc_sched

Slot scheduler and controller for the JT12 output accumulators. It runs the 24-slot FM frame (6 channels × 4 operators) and decodes each channel's algorithm and pan setting. From these it produces the per-slot `sum_en` strobes for the left and right accumulator instances and the frame-boundary `zero` strobe. Register writes are shadowed so configuration changes take effect only at a frame boundary, never mid-frame.

## Interface
Parameters:
- `NCH`, 6: number of FM channels; frame length is `4*NCH` slots.
- `SW`, 5: slot counter width; must satisfy `2**SW >= 4*NCH`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `clk_en`, input, 1: slot advance; all state except staging registers updates only when high.
- `cfg_we`, input, 1: configuration write strobe.
- `cfg_ch`, input, 3: target channel, 0..NCH-1; values ≥ NCH are ignored.
- `cfg_alg`, input, 3: algorithm 0..7.
- `cfg_pan`, input, 2: {L,R} enables.
- `dac_en`, input, 1: channel NCH-1 replaced by DAC; sampled at frame boundary.
- `slot`, output, SW: current slot 0..4*NCH-1.
- `ch`, output, 3: channel of current slot.
- `op`, output, 2: operator of current slot, encoded 0=S1, 1=S3, 2=S2, 3=S4.
- `sum_en_l`, output, 1: left accumulator sum enable.
- `sum_en_r`, output, 1: right accumulator sum enable.
- `zero`, output, 1: frame start; drives `zero` of both accumulators.
- `dac_sel`, output, 1: the current slot carries the DAC sample instead of operator output.

## Operation
- Slot order: operator group is outer (S1, S3, S2, S4) and channel is inner. So `slot = op*NCH + ch`.
- Carrier decode, by algorithm:
  - alg 0–3: S4 only.
  - alg 4: S2 and S4.
  - alg 5–6: S3, S2 and S4.
  - alg 7: all four operators.
- `sum_en_l = carrier & pan_l[ch] & ~dac_mute`; `sum_en_r` is the same using `pan_r`.
- DAC mode: when `dac_act` is set, every slot of channel NCH-1 has `sum_en_l = sum_en_r = 0`. In slot 4*NCH-1 (S4 of that channel), `dac_sel = 1`, and the summing of the externally muxed DAC value is gated by pan alone.
- `zero = 1` exactly in slot 0, with `sum_en` still decoded normally for slot 0.
- Configuration writes:
  - A `cfg_we` write loads the staging registers `alg_s[cfg_ch]` and `pan_s[cfg_ch]` on any clk edge, independent of `clk_en`.
  - Active registers `alg_a`, `pan_a` and `dac_act` copy from staging on the clk_en edge that moves `slot` from 4*NCH-1 to 0.
  - A write in that same cycle is bypassed into the active copy, i.e. the newest value wins.

## Timing
- Reset values:
  - `slot = 4*NCH-1`, `ch = NCH-1`, `op = 3`.
  - `sum_en_l = sum_en_r = zero = dac_sel = 0`.
  - Staging and active algorithm = 0, pan = 2'b11, `dac_act = 0`.
- All outputs are registered. On each clk_en edge, `slot` advances by 1 and wraps 4*NCH-1 → 0. The outputs for the new slot are computed from the next-slot value, so outputs and `slot` are always aligned with zero latency.
- The first clk_en after reset yields slot 0 with `zero = 1`.
- When `clk_en` is low, all outputs hold.
- Reset asserted mid-frame returns the block immediately to the reset values. The partial frame is discarded, and the accumulator sees no `zero` until the next slot 0.
- `cfg_ch ≥ NCH`: the write is dropped with no side effect.

## Structure
- The shared package `jt12_pkg` holds:
  - the operator encoding constants (S1=0, S3=1, S2=2, S4=3),
  - `FRAME_SLOTS = 4*NCH`,
  - the 8-entry carrier mask constant indexed by algorithm.
- One combinational sub-module, `jt12_carrier_dec` (alg, op → carrier), shared with the operator pipeline.
- Top level contents: slot counter, ch/op split, staging and active register files, output register stage.

## Test plan
- Reset, then 24 clk_en pulses with all alg = 0 and pan = 11 → `zero` high only at slot 0; `sum_en_l = sum_en_r = 1` only at slots 18–23.
- Write ch 2 alg 7 and pan 10 at slot 5 → frame in progress is unchanged. From the next slot 0: `sum_en_l = 1` at slots 2, 8, 14, 20; `sum_en_r = 0` at those slots.
- Write ch 0 alg 4 in the same cycle as the 23→0 clk_en edge → slot 12 (S2, ch0) and slot 18 both have `sum_en` set in the new frame.
- `dac_en = 1` → ch5 `sum_en = 0` in slots 5, 11, 17; slot 23 has `dac_sel = 1` with `sum_en` following pan.
- Toggle `clk_en` every 3rd clk → outputs change only on clk_en edges. Also assert `rst` at slot 10 → `slot = 23` and all strobes 0 immediately; the next clk_en gives slot 0 with `zero = 1`.
